// File: rtl/dose_scheduler.sv
// -----------------------------------------------------------------------------
// dose_scheduler
//
// Medication reminder sequencer. Holds NUM_SLOTS programmable dose times and
// compares them against a free-running time-of-day counter that advances on
// each tick strobe. Slots that fall due are latched as pending. A fixed-priority
// arbiter (lowest index first) picks one pending slot. The scheduler then
// raises an alarm and waits for the patient to acknowledge. If no acknowledge
// arrives, it escalates through timed retries. It finally emits one event
// record per dose downstream.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset (dominates all inputs)
//   ena           : global enable; low freezes every register
//   tick          : single-cycle time-advance strobe
//   cfg_we        : slot configuration write strobe
//   cfg_slot      : slot index written by cfg_we
//   cfg_time      : dose time written into the slot
//   cfg_en        : slot enable written into the slot (0 also drops pending)
//   ack           : patient acknowledge, level sampled every enabled cycle
//   log_ready     : downstream accepts the record
//   time_now      : current time-of-day counter
//   alarm         : alert active
//   alarm_slot    : slot currently being alerted
//   attempt       : current alert attempt, 1-based, 0 when not alerting
//   log_valid     : record available
//   log_data      : {missed, slot, time_now when the outcome was decided}
//   overrun       : sticky, a slot fell due while it was still pending
//   dbg_state_o   : FSM state (IDLE=0, ALERT=1, LOG=2) for observation
//
// Log handshake: a record transfers on every cycle where log_valid and
// log_ready are both high (with ena high). log_valid never drops and log_data
// never changes while a record is waiting. log_ready may be high before
// log_valid and has no effect until a record is presented.
// -----------------------------------------------------------------------------
module dose_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int TIME_W      = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRIES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     tick,
  input  logic                     cfg_we,
  input  logic [SLOT_W-1:0]        cfg_slot,
  input  logic [TIME_W-1:0]        cfg_time,
  input  logic                     cfg_en,
  input  logic                     ack,
  input  logic                     log_ready,
  output logic [TIME_W-1:0]        time_now,
  output logic                     alarm,
  output logic [SLOT_W-1:0]        alarm_slot,
  output logic [2:0]               attempt,
  output logic                     log_valid,
  output logic [SLOT_W+TIME_W:0]   log_data,
  output logic                     overrun,
  output logic [1:0]               dbg_state_o
);

  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       ATT_MAX  = 3'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALERT = 2'd1,
    ST_LOG   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                   state_q;
  logic [TIME_W-1:0]        time_q;
  logic [TIME_W-1:0]        slot_time_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     slot_en_q;
  logic [NUM_SLOTS-1:0]     pending_q;
  logic                     overrun_q;
  logic                     alarm_q;
  logic [SLOT_W-1:0]        alarm_slot_q;
  logic [2:0]               attempt_q;
  logic [TMR_W-1:0]         timer_q;
  logic                     log_valid_q;
  logic [SLOT_W+TIME_W:0]   log_data_q;

  // ---------------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0]     due_vec;
  logic [NUM_SLOTS-1:0]     cfg_clr_vec;
  logic [NUM_SLOTS-1:0]     cand_vec;
  logic                     sel_valid;
  logic [SLOT_W-1:0]        sel_idx;
  logic                     tmr_expire;
  logic                     give_up;
  logic                     resolve;
  logic [NUM_SLOTS-1:0]     pending_d;
  logic                     overrun_d;
  logic [TIME_W-1:0]        time_d;

  always_comb begin
    due_vec     = '0;
    cfg_clr_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // Compare against the pre-increment time so a slot set to T fires on
      // the tick that moves the clock away from T.
      due_vec[i]     = tick & slot_en_q[i] & (slot_time_q[i] == time_q);
      cfg_clr_vec[i] = cfg_we & ~cfg_en & (cfg_slot == SLOT_W'(i));
    end
  end

  // Lowest index wins. A slot being disabled this very cycle is not picked.
  always_comb begin
    cand_vec  = pending_q & ~cfg_clr_vec;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cand_vec[i]) begin
        sel_valid = 1'b1;
        sel_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    tmr_expire = tick & (timer_q == TMR_LAST);
    give_up    = tmr_expire & (attempt_q >= ATT_MAX);
    // The alerted slot is resolved by an acknowledge or by running out of
    // attempts; acknowledge takes precedence in the FSM below.
    resolve    = (state_q == ST_ALERT) & (ack | give_up);
  end

  // Pending update order: resolution clears, a fresh due sets again (it is a
  // new dose), and a cfg disable clears last so it wins over both.
  always_comb begin
    pending_d = pending_q;
    if (resolve) begin
      pending_d[alarm_slot_q] = 1'b0;
    end
    pending_d = pending_d | due_vec;
    pending_d = pending_d & ~cfg_clr_vec;
  end

  always_comb begin
    overrun_d = overrun_q | (|(due_vec & pending_q));
    time_d    = tick ? time_q + 1'b1 : time_q;
  end

  // ---------------------------------------------------------------------------
  // Sequential logic: time base, slot table, pending set and the alert FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      time_q       <= '0;
      slot_en_q    <= '0;
      pending_q    <= '0;
      overrun_q    <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_slot_q <= '0;
      attempt_q    <= '0;
      timer_q      <= '0;
      log_valid_q  <= 1'b0;
      log_data_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_time_q[i] <= '0;
      end
    end else if (ena) begin
      time_q    <= time_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;

      if (cfg_we) begin
        slot_time_q[cfg_slot] <= cfg_time;
        slot_en_q[cfg_slot]   <= cfg_en;
      end

      case (state_q)
        ST_IDLE: begin
          if (sel_valid) begin
            state_q      <= ST_ALERT;
            alarm_q      <= 1'b1;
            alarm_slot_q <= sel_idx;
            attempt_q    <= 3'd1;
            timer_q      <= '0;
          end
        end

        ST_ALERT: begin
          if (ack) begin
            state_q     <= ST_LOG;
            alarm_q     <= 1'b0;
            attempt_q   <= '0;
            log_valid_q <= 1'b1;
            log_data_q  <= {1'b0, alarm_slot_q, time_q};
          end else if (tick) begin
            if (tmr_expire) begin
              if (give_up) begin
                state_q     <= ST_LOG;
                alarm_q     <= 1'b0;
                attempt_q   <= '0;
                log_valid_q <= 1'b1;
                log_data_q  <= {1'b1, alarm_slot_q, time_q};
              end else begin
                attempt_q <= attempt_q + 3'd1;
                timer_q   <= '0;
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end

        ST_LOG: begin
          if (log_ready) begin
            state_q     <= ST_IDLE;
            log_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          alarm_q     <= 1'b0;
          attempt_q   <= '0;
          log_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign time_now    = time_q;
  assign alarm       = alarm_q;
  assign alarm_slot  = alarm_slot_q;
  assign attempt     = attempt_q;
  assign log_valid   = log_valid_q;
  assign log_data    = log_data_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dose_scheduler.sv
module tb_dose_scheduler;

  localparam int NS = 4;
  localparam int AT = 16;
  localparam int MR = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic [7:0]  cfg_time = '0;
  logic        cfg_en = 1'b0;
  logic        ack = 1'b0;
  logic        log_ready = 1'b0;
  logic [7:0]  time_now;
  logic        alarm;
  logic [1:0]  alarm_slot;
  logic [2:0]  attempt;
  logic        log_valid;
  logic [10:0] log_data;
  logic        overrun;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  dose_scheduler dut (
    .clk(clk), .rst(rst), .ena(ena), .tick(tick),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_time(cfg_time), .cfg_en(cfg_en),
    .ack(ack), .log_ready(log_ready),
    .time_now(time_now), .alarm(alarm), .alarm_slot(alarm_slot), .attempt(attempt),
    .log_valid(log_valid), .log_data(log_data), .overrun(overrun),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model: phase 0 waiting, 1 alerting, 2 holding a record
  // ---------------------------------------------------------------------------
  int m_time;
  int m_st [NS];
  bit m_en [NS];
  bit m_pend [NS];
  bit m_over;
  int m_phase;
  int m_slot;
  int m_att;
  int m_timer;
  int m_ld;

  task automatic model_update();
    bit due [NS];
    bit np [NS];
    int sel;
    if (rst) begin
      m_time = 0; m_over = 0; m_phase = 0; m_slot = 0; m_att = 0; m_timer = 0; m_ld = 0;
      for (int i = 0; i < NS; i++) begin m_st[i] = 0; m_en[i] = 0; m_pend[i] = 0; end
      return;
    end
    if (!ena) return;
    for (int i = 0; i < NS; i++) begin
      due[i] = tick && m_en[i] && (m_st[i] == m_time);
      np[i]  = m_pend[i];
    end
    case (m_phase)
      0: begin
        sel = -1;
        for (int i = NS - 1; i >= 0; i--)
          if (m_pend[i] && !(cfg_we && !cfg_en && int'(cfg_slot) == i)) sel = i;
        if (sel >= 0) begin m_phase = 1; m_slot = sel; m_att = 1; m_timer = 0; end
      end
      1: begin
        if (ack) begin
          np[m_slot] = 0; m_ld = (m_slot << 8) | m_time; m_phase = 2;
        end else if (tick) begin
          if (m_timer == AT - 1) begin
            if (m_att < MR) begin m_att++; m_timer = 0; end
            else begin np[m_slot] = 0; m_ld = 1024 | (m_slot << 8) | m_time; m_phase = 2; end
          end else m_timer++;
        end
      end
      default: if (log_ready) m_phase = 0;
    endcase
    for (int i = 0; i < NS; i++)
      if (due[i]) begin
        if (m_pend[i]) m_over = 1;
        np[i] = 1;
      end
    if (cfg_we) begin
      m_st[cfg_slot] = int'(cfg_time);
      m_en[cfg_slot] = cfg_en;
      if (!cfg_en) np[cfg_slot] = 0;
    end
    for (int i = 0; i < NS; i++) m_pend[i] = np[i];
    if (tick) m_time = (m_time + 1) % 256;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input bit t, input bit a, input bit r);
    ena = 1; rst = 0; cfg_we = 0; tick = t; ack = a; log_ready = r;
    step();
  endtask

  task automatic cfg_write(input int slot, input int tm, input bit en);
    ena = 1; rst = 0; tick = 0; ack = 0; log_ready = 0;
    cfg_we = 1; cfg_slot = 2'(slot); cfg_time = 8'(tm); cfg_en = en;
    step();
    cfg_we = 0;
  endtask

  task automatic do_reset();
    rst = 1; ena = 0; tick = 0; cfg_we = 0; ack = 0; log_ready = 0;
    step(); step();
    rst = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      rst = 1; ena = 1'($urandom_range(0, 1)); tick = 1'($urandom_range(0, 1));
      cfg_we = 1; cfg_slot = 2'($urandom_range(0, 3)); cfg_time = 8'($urandom_range(0, 255));
      cfg_en = 1; ack = 1; log_ready = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if ({time_now, alarm, alarm_slot, attempt, log_valid, log_data, overrun} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: got time=%0d alarm=%0b slot=%0d att=%0d lv=%0b ld=%0h ov=%0b expected all 0",
                 time_now, alarm, alarm_slot, attempt, log_valid, log_data, overrun);
      end
      n_checks++;
      if (dbg_state_o !== 2'd0) begin
        n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o);
      end
    end
    cfg_we = 0; ack = 0;
    cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b0 || time_now !== 8'd0) begin
      n_errors++; $display("FAIL reset_release: got alarm=%0b time=%0d expected 0 0", alarm, time_now);
    end
  endtask

  task automatic test_ack_path();
    logic [10:0] exp_ld;
    do_reset();
    cfg_write(1, 5, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    n_checks++;
    if (time_now !== 8'd5 || alarm !== 1'b0) begin
      n_errors++; $display("FAIL ack_pre_due: got time=%0d alarm=%0b expected 5 0", time_now, alarm);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (alarm !== 1'b0) begin
      n_errors++; $display("FAIL ack_latency: got alarm=%0b expected 0 on due cycle", alarm);
    end
    cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1 || alarm_slot !== 2'd1 || attempt !== 3'd1) begin
      n_errors++; $display("FAIL ack_alarm: got alarm=%0b slot=%0d att=%0d expected 1 1 1", alarm, alarm_slot, attempt);
    end
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 0);
    exp_ld = {1'b0, 2'd1, 8'd8};
    n_checks++;
    if (log_valid !== 1'b1 || log_data !== exp_ld || alarm !== 1'b0 || attempt !== 3'd0) begin
      n_errors++; $display("FAIL ack_log: got lv=%0b ld=%0h alarm=%0b att=%0d expected 1 %0h 0 0",
                           log_valid, log_data, alarm, attempt, exp_ld);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      n_checks++;
      if (log_valid !== 1'b1 || log_data !== exp_ld) begin
        n_errors++; $display("FAIL ack_hold: got lv=%0b ld=%0h expected 1 %0h", log_valid, log_data, exp_ld);
      end
    end
    cyc(0, 0, 1);
    n_checks++;
    if (log_valid !== 1'b0 || dbg_state_o !== 2'd0 || alarm !== 1'b0) begin
      n_errors++; $display("FAIL ack_drain: got lv=%0b state=%0d alarm=%0b expected 0 0 0", log_valid, dbg_state_o, alarm);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_write(0, 10, 1);
    for (int i = 0; i < 11; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int j = 1; j <= 48; j++) begin
      cyc(1, 0, 0);
      if (j < 48) begin
        n_checks++;
        if (alarm !== 1'b1 || attempt !== 3'(1 + j / AT)) begin
          n_errors++; $display("FAIL timeout_attempt: tick %0d got alarm=%0b att=%0d expected 1 %0d",
                               j, alarm, attempt, 1 + j / AT);
        end
      end
    end
    n_checks++;
    if (log_valid !== 1'b1 || log_data !== {1'b1, 2'd0, 8'd58} || alarm !== 1'b0 || attempt !== 3'd0) begin
      n_errors++; $display("FAIL timeout_miss: got lv=%0b ld=%0h alarm=%0b att=%0d expected 1 %0h 0 0",
                           log_valid, log_data, alarm, attempt, {1'b1, 2'd0, 8'd58});
    end
    cyc(0, 0, 1);
  endtask

  task automatic test_arbitration();
    do_reset();
    cfg_write(2, 20, 1);
    cfg_write(3, 20, 1);
    for (int i = 0; i < 21; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1 || alarm_slot !== 2'd2) begin
      n_errors++; $display("FAIL arb_first: got alarm=%0b slot=%0d expected 1 2", alarm, alarm_slot);
    end
    cyc(0, 1, 0);
    n_checks++;
    if (log_data !== {1'b0, 2'd2, 8'd21}) begin
      n_errors++; $display("FAIL arb_first_log: got %0h expected %0h", log_data, {1'b0, 2'd2, 8'd21});
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1 || alarm_slot !== 2'd3 || attempt !== 3'd1) begin
      n_errors++; $display("FAIL arb_second: got alarm=%0b slot=%0d att=%0d expected 1 3 1", alarm, alarm_slot, attempt);
    end
    for (int j = 1; j < 48; j++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    n_checks++;
    if (log_valid !== 1'b1 || log_data !== {1'b0, 2'd3, 8'd68}) begin
      n_errors++; $display("FAIL arb_ack_vs_timeout: got lv=%0b ld=%0h expected 1 %0h",
                           log_valid, log_data, {1'b0, 2'd3, 8'd68});
    end
    cyc(0, 0, 1);
  endtask

  task automatic test_wrap_overrun();
    do_reset();
    cfg_write(0, 250, 1);
    cfg_write(1, 255, 1);
    for (int i = 0; i < 516; i++) begin
      cyc(1, 1, 0);
      n_checks++;
      if (time_now !== 8'((i + 1) % 256) || overrun !== (i >= 511)) begin
        n_errors++; $display("FAIL wrap_time_overrun: step %0d got time=%0d ov=%0b expected %0d %0b",
                             i, time_now, overrun, (i + 1) % 256, i >= 511);
      end
      if (i >= 252) begin
        n_checks++;
        if (log_valid !== 1'b1 || log_data !== {1'b0, 2'd0, 8'd252}) begin
          n_errors++; $display("FAIL wrap_log_hold: step %0d got lv=%0b ld=%0h expected 1 %0h",
                               i, log_valid, log_data, {1'b0, 2'd0, 8'd252});
        end
      end
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1 || alarm_slot !== 2'd0 || overrun !== 1'b1) begin
      n_errors++; $display("FAIL wrap_after_drain: got alarm=%0b slot=%0d ov=%0b expected 1 0 1", alarm, alarm_slot, overrun);
    end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    cfg_write(2, 3, 1);
    cfg_write(3, 3, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    n_checks++;
    if (time_now !== 8'd24 || attempt !== 3'd2 || alarm_slot !== 2'd2) begin
      n_errors++; $display("FAIL freeze_setup: got time=%0d att=%0d slot=%0d expected 24 2 2", time_now, attempt, alarm_slot);
    end
    for (int i = 0; i < 30; i++) begin
      ena = 0; tick = 1; ack = 1; log_ready = 1;
      cfg_we = 1; cfg_slot = 2'(i % 4); cfg_en = 0; cfg_time = 8'(i);
      step();
      n_checks++;
      if (time_now !== 8'd24 || attempt !== 3'd2 || alarm !== 1'b1) begin
        n_errors++; $display("FAIL freeze_hold: got time=%0d att=%0d alarm=%0b expected 24 2 1", time_now, attempt, alarm);
      end
    end
    cyc(0, 1, 0);
    n_checks++;
    if (log_valid !== 1'b1 || log_data !== {1'b0, 2'd2, 8'd24}) begin
      n_errors++; $display("FAIL freeze_resume: got lv=%0b ld=%0h expected 1 %0h", log_valid, log_data, {1'b0, 2'd2, 8'd24});
    end
    rst = 1; ena = 1; log_ready = 0; tick = 1; ack = 0;
    step();
    rst = 0;
    n_checks++;
    if (log_valid !== 1'b0 || overrun !== 1'b0 || time_now !== 8'd0 || alarm !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_log: got lv=%0b ov=%0b time=%0d alarm=%0b expected 0 0 0 0",
                           log_valid, overrun, time_now, alarm);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      n_checks++;
      if (alarm !== 1'b0 || log_valid !== 1'b0) begin
        n_errors++; $display("FAIL reset_pending_cleared: got alarm=%0b lv=%0b expected 0 0", alarm, log_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < NS; s++) cfg_write(s, $urandom_range(5, 60), 1);
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 999) == 0);
      ena       = ($urandom_range(0, 15) != 0);
      tick      = 1'($urandom_range(0, 1));
      ack       = ($urandom_range(0, 19) == 0);
      log_ready = ($urandom_range(0, 2) != 0);
      cfg_we    = ($urandom_range(0, 49) == 0);
      cfg_slot  = 2'($urandom_range(0, 3));
      cfg_time  = 8'((m_time + $urandom_range(0, 40)) % 256);
      cfg_en    = ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if (time_now !== 8'(m_time) || overrun !== m_over || alarm !== (m_phase == 1) ||
          log_valid !== (m_phase == 2) || attempt !== ((m_phase == 1) ? 3'(m_att) : 3'd0) ||
          dbg_state_o !== 2'(m_phase)) begin
        n_errors++;
        $display("FAIL rand_core: cycle %0d got time=%0d ov=%0b alarm=%0b lv=%0b att=%0d st=%0d expected %0d %0b %0b %0b %0d %0d",
                 c, time_now, overrun, alarm, log_valid, attempt, dbg_state_o,
                 m_time, m_over, m_phase == 1, m_phase == 2, (m_phase == 1) ? m_att : 0, m_phase);
      end
      if (m_phase == 1) begin
        n_checks++;
        if (alarm_slot !== 2'(m_slot)) begin
          n_errors++; $display("FAIL rand_alarm_slot: cycle %0d got %0d expected %0d", c, alarm_slot, m_slot);
        end
      end
      if (m_phase == 2) begin
        n_checks++;
        if (log_data !== 11'(m_ld)) begin
          n_errors++; $display("FAIL rand_log_data: cycle %0d got %0h expected %0h", c, log_data, m_ld);
        end
      end
    end
    rst = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_ack_path();
    test_timeout();
    test_arbitration();
    test_wrap_overrun();
    test_freeze_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
